// File: rtl/drsstc_pkg.sv
// Shared DRSSTC controller definitions: config word layout, interrupter
// state encoding and the on-time clamp / run-permission helpers.
package drsstc_pkg;

   localparam int unsigned CONF_PAR_NUM = 5;
   localparam int unsigned CONF_PAR_MAX = 16;

   // Word positions inside the UART config array
   localparam int unsigned PAR_PERIOD = 0;
   localparam int unsigned PAR_ON     = 1;
   localparam int unsigned PAR_BURST  = 2;
   localparam int unsigned PAR_GAP    = 3;
   localparam int unsigned PAR_EN     = 4;

   typedef enum logic [1:0] {IDLE, ON, OFF, GAP} intr_state_t;

   typedef logic [CONF_PAR_MAX-1:0] word_t;

   // One complete interrupter configuration
   typedef struct packed {
      word_t period;
      word_t on_time;
      word_t burst_len;
      word_t burst_gap;
      word_t enable;
   } intr_cfg_t;

   // On-time clamped to the hard limit and to period-1 so the off phase is never empty
   function automatic word_t calc_eff_on(input intr_cfg_t c, input word_t max_on);
      word_t e;
      e = c.on_time;
      if (e > max_on) e = max_on;
      if (e > c.period - word_t'(1)) e = c.period - word_t'(1);
      return e;
   endfunction

   // A config that cannot produce a legal pulse is treated as disabled
   function automatic logic run_allowed(input intr_cfg_t c);
      return (c.enable != '0) && (c.period >= word_t'(2)) && (c.on_time != '0);
   endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running prescaler producing a one-clock timing tick every TICK_DIV clocks.
// Ports: clk, rst (async active-high), tick (registered, high when count is TICK_DIV-1).
module tick_prescaler #(
   parameter int unsigned TICK_DIV = 50
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // Wrapping count 0..TICK_DIV-1
   always_comb begin
      cnt_d = cnt_q + CW'(1);
      if (cnt_q == LAST) cnt_d = '0;
   end

   // tick is registered from the next count so it is high while cnt_q == LAST
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
         tick  <= (LAST == '0);
      end else begin
         cnt_q <= cnt_d;
         tick  <= (cnt_d == LAST);
      end
   end

endmodule

// File: rtl/interrupter_gen.sv
// DRSSTC interrupter: turns the decoded UART config into a gate-enable pulse
// train with continuous or burst modes and on-time clamping. New settings take
// effect at period boundaries; a disable strobe stops output on the next clock.
// Ports: clk, rst (async active-high), sh_reg (config words), is_data_ready
// (strobe, sh_reg valid same cycle), out (registered gate enable), busy (not IDLE).
module interrupter_gen #(
   parameter int unsigned CONF_PAR_NUM = 5,
   parameter int unsigned CONF_PAR_MAX = 16,
   parameter int unsigned TICK_DIV     = 50,
   parameter int unsigned MAX_ON_TICKS = 200
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic [CONF_PAR_NUM-1:0][CONF_PAR_MAX-1:0] sh_reg,
   input  logic                                   is_data_ready,
   output logic                                   out,
   output logic                                   busy
);

   import drsstc_pkg::*;

   localparam word_t MAX_ON = word_t'(MAX_ON_TICKS);

   logic        tick;
   intr_state_t state_q, state_d;
   word_t       cnt_q, cnt_d;
   word_t       pcnt_q, pcnt_d;
   intr_cfg_t   shadow_q, shadow_d;
   intr_cfg_t   staging_q, staging_d;
   logic        pending_q, pending_d;

   intr_cfg_t   cfg_in;
   intr_cfg_t   cfg_new;
   logic        kill;
   logic        apply;

   tick_prescaler #(.TICK_DIV(TICK_DIV)) u_presc (
      .clk  (clk),
      .rst  (rst),
      .tick (tick)
   );

   // Unpack the incoming config array
   always_comb begin
      cfg_in.period    = word_t'(sh_reg[PAR_PERIOD]);
      cfg_in.on_time   = word_t'(sh_reg[PAR_ON]);
      cfg_in.burst_len = word_t'(sh_reg[PAR_BURST]);
      cfg_in.burst_gap = word_t'(sh_reg[PAR_GAP]);
      cfg_in.enable    = word_t'(sh_reg[PAR_EN]);
   end

   // Config an apply point would use: a same-cycle strobe beats staging, staging beats shadow
   always_comb begin
      cfg_new = shadow_q;
      if (pending_q)     cfg_new = staging_q;
      if (is_data_ready) cfg_new = cfg_in;
   end

   assign kill = is_data_ready && (cfg_in.enable == '0);

   // Next-state, counters and config staging
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      pcnt_d    = pcnt_q;
      shadow_d  = shadow_q;
      staging_d = staging_q;
      pending_d = pending_q;
      apply     = 1'b0;

      if (is_data_ready) begin
         staging_d = cfg_in;
         pending_d = 1'b1;
      end

      if (kill) begin
         state_d   = IDLE;
         shadow_d  = cfg_in;
         pending_d = 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               apply = 1'b1;
               if (tick && run_allowed(cfg_new)) begin
                  state_d = ON;
                  cnt_d   = calc_eff_on(cfg_new, MAX_ON);
                  pcnt_d  = cfg_new.burst_len;
               end
            end
            ON: begin
               if (tick) begin
                  if (cnt_q == word_t'(1)) begin
                     // Shadow is stable through ON, so it still holds this pulse's settings
                     state_d = OFF;
                     cnt_d   = shadow_q.period - calc_eff_on(shadow_q, MAX_ON);
                  end else begin
                     cnt_d = cnt_q - word_t'(1);
                  end
               end
            end
            OFF: begin
               if (tick) begin
                  if (cnt_q == word_t'(1)) begin
                     apply = 1'b1;
                     if (!run_allowed(cfg_new)) begin
                        state_d = IDLE;
                     end else if (cfg_new.burst_len == '0) begin
                        state_d = ON;
                        cnt_d   = calc_eff_on(cfg_new, MAX_ON);
                     end else if (pcnt_q > word_t'(1)) begin
                        state_d = ON;
                        cnt_d   = calc_eff_on(cfg_new, MAX_ON);
                        pcnt_d  = pcnt_q - word_t'(1);
                     end else if (cfg_new.burst_gap != '0) begin
                        state_d = GAP;
                        cnt_d   = cfg_new.burst_gap;
                     end else begin
                        state_d = ON;
                        cnt_d   = calc_eff_on(cfg_new, MAX_ON);
                        pcnt_d  = cfg_new.burst_len;
                     end
                  end else begin
                     cnt_d = cnt_q - word_t'(1);
                  end
               end
            end
            GAP: begin
               if (tick) begin
                  if (cnt_q == word_t'(1)) begin
                     apply = 1'b1;
                     if (!run_allowed(cfg_new)) begin
                        state_d = IDLE;
                     end else begin
                        state_d = ON;
                        cnt_d   = calc_eff_on(cfg_new, MAX_ON);
                        pcnt_d  = cfg_new.burst_len;
                     end
                  end else begin
                     cnt_d = cnt_q - word_t'(1);
                  end
               end
            end
            default: state_d = IDLE;
         endcase

         if (apply) begin
            shadow_d  = cfg_new;
            pending_d = 1'b0;
         end
      end
   end

   // State register; out and busy are flops decoded from the next state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         pcnt_q    <= '0;
         shadow_q  <= '0;
         staging_q <= '0;
         pending_q <= 1'b0;
         out       <= 1'b0;
         busy      <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         pcnt_q    <= pcnt_d;
         shadow_q  <= shadow_d;
         staging_q <= staging_d;
         pending_q <= pending_d;
         out       <= (state_d == ON);
         busy      <= (state_d != IDLE);
      end
   end

endmodule

// File: tb/tb_interrupter_gen.sv
// Self-checking bench for interrupter_gen: directed scenarios plus random
// reconfiguration, compared against a deadline-based behavioural model.
module tb_interrupter_gen;

   localparam int TD     = 2;
   localparam int MAX_ON = 200;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [4:0][15:0] sh_reg = '0;
   logic             is_data_ready = 1'b0;
   logic             out;
   logic             busy;

   int n_chk = 0;
   int n_err = 0;

   interrupter_gen #(
      .CONF_PAR_NUM (5),
      .CONF_PAR_MAX (16),
      .TICK_DIV     (TD),
      .MAX_ON_TICKS (MAX_ON)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .sh_reg        (sh_reg),
      .is_data_ready (is_data_ready),
      .out           (out),
      .busy          (busy)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   typedef struct {
      int per;
      int on;
      int bl;
      int gap;
      int en;
   } mcfg_t;

   localparam int M_IDLE = 0, M_ON = 1, M_OFF = 2, M_GAP = 3;

   mcfg_t m_shadow = '{0, 0, 0, 0, 0};
   mcfg_t m_stg    = '{0, 0, 0, 0, 0};
   bit    m_pend   = 0;
   int    m_seg    = M_IDLE;
   int    m_deadline = 0;
   int    m_left   = 0;
   int    m_k      = 0;

   function automatic int m_eff(input mcfg_t c);
      int e = c.on;
      if (e > MAX_ON) e = MAX_ON;
      if (e > c.per - 1) e = c.per - 1;
      return e;
   endfunction

   function automatic bit m_ok(input mcfg_t c);
      return (c.en != 0) && (c.per >= 2) && (c.on != 0);
   endfunction

   // Each pulse phase is scheduled as an absolute clock-edge deadline
   always @(posedge clk or posedge rst) begin
      mcfg_t in_c, now_c;
      bit    tk;
      if (rst) begin
         m_shadow = '{0, 0, 0, 0, 0};
         m_stg    = '{0, 0, 0, 0, 0};
         m_pend   = 0;
         m_seg    = M_IDLE;
         m_k      = 0;
      end else begin
         tk   = ((m_k % TD) == TD - 1);
         in_c = '{int'(sh_reg[0]), int'(sh_reg[1]), int'(sh_reg[2]),
                  int'(sh_reg[3]), int'(sh_reg[4])};
         if (is_data_ready && in_c.en == 0) begin
            m_seg = M_IDLE; m_shadow = in_c; m_pend = 0;
         end else begin
            if (is_data_ready) begin m_stg = in_c; m_pend = 1; end
            now_c = m_pend ? m_stg : m_shadow;
            case (m_seg)
               M_IDLE: begin
                  m_shadow = now_c; m_pend = 0;
                  if (tk && m_ok(now_c)) begin
                     m_seg = M_ON; m_deadline = m_k + m_eff(now_c) * TD; m_left = now_c.bl;
                  end
               end
               M_ON: if (m_k == m_deadline) begin
                  m_seg = M_OFF;
                  m_deadline = m_k + (m_shadow.per - m_eff(m_shadow)) * TD;
               end
               M_OFF: if (m_k == m_deadline) begin
                  m_shadow = now_c; m_pend = 0;
                  if (!m_ok(now_c)) m_seg = M_IDLE;
                  else begin
                     if (now_c.bl == 0) ;
                     else if (m_left > 1) m_left--;
                     else if (now_c.gap != 0) m_seg = M_GAP;
                     else m_left = now_c.bl;
                     if (m_seg == M_GAP) m_deadline = m_k + now_c.gap * TD;
                     else begin m_seg = M_ON; m_deadline = m_k + m_eff(now_c) * TD; end
                  end
               end
               default: if (m_k == m_deadline) begin
                  m_shadow = now_c; m_pend = 0;
                  if (!m_ok(now_c)) m_seg = M_IDLE;
                  else begin
                     m_seg = M_ON; m_deadline = m_k + m_eff(now_c) * TD; m_left = now_c.bl;
                  end
               end
            endcase
         end
         m_k++;
      end
   end

   // ---------------- helpers ----------------
   task automatic chk(input string tag, input logic obs, input logic exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0b expected=%0b at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic chk_int(input string tag, input int obs, input int exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
      end
   endtask

   // Advance n clocks, comparing out/busy with the model after every edge
   task automatic cyc(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         chk("model_out", out, logic'(m_seg == M_ON));
         chk("model_busy", busy, logic'(m_seg != M_IDLE));
      end
   endtask

   task automatic cfg(input int per, input int on, input int bl, input int gap, input int en);
      sh_reg[0] = 16'(per);
      sh_reg[1] = 16'(on);
      sh_reg[2] = 16'(bl);
      sh_reg[3] = 16'(gap);
      sh_reg[4] = 16'(en);
      is_data_ready = 1'b1;
      cyc(1);
      is_data_ready = 1'b0;
   endtask

   task automatic wait_high();
      int t = 0;
      while (out !== 1'b1 && t < 3000) begin cyc(1); t++; end
      chk("wait_high", out, 1'b1);
   endtask

   // Length of the current/next high phase and the low phase that follows, in clocks
   task automatic meas(output int hi, output int lo);
      int t = 0;
      hi = 0; lo = 0;
      while (out !== 1'b1 && t < 5000) begin cyc(1); t++; end
      while (out === 1'b1 && t < 5000) begin cyc(1); t++; hi++; end
      while (out !== 1'b1 && t < 5000) begin cyc(1); t++; lo++; end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int hi, lo;
      #1;
      chk("reset_out", out, 1'b0);
      chk("reset_busy", busy, 1'b0);
      #12 rst = 1'b0;
      cyc(10);

      // Continuous mode
      cfg(10, 3, 0, 0, 1);
      meas(hi, lo); chk_int("cont_hi", hi, 6); chk_int("cont_lo", lo, 14);
      meas(hi, lo); chk_int("cont_hi2", hi, 6); chk_int("cont_lo2", lo, 14);
      chk("cont_busy", busy, 1'b1);

      // Burst mode
      cfg(10, 3, 0, 0, 0);
      cyc(5);
      cfg(10, 2, 3, 20, 1);
      meas(hi, lo); chk_int("burst_hi1", hi, 4); chk_int("burst_lo1", lo, 16);
      meas(hi, lo); chk_int("burst_hi2", hi, 4); chk_int("burst_lo2", lo, 16);
      meas(hi, lo); chk_int("burst_hi3", hi, 4); chk_int("burst_gap", lo, 56);
      meas(hi, lo); chk_int("burst_hi4", hi, 4); chk_int("burst_lo4", lo, 16);

      // Clamping
      cfg(10, 2, 3, 20, 0);
      cyc(3);
      cfg(10, 50, 0, 0, 1);
      meas(hi, lo); chk_int("clamp_per_hi", hi, 18); chk_int("clamp_per_lo", lo, 2);
      cfg(10, 50, 0, 0, 0);
      cyc(3);
      cfg(1000, 300, 0, 0, 1);
      meas(hi, lo); chk_int("clamp_max_hi", hi, 400); chk_int("clamp_max_lo", lo, 1600);

      // Mid-pulse reconfiguration
      cfg(1000, 300, 0, 0, 0);
      cyc(3);
      cfg(10, 3, 0, 0, 1);
      wait_high();
      cyc(2);
      cfg(10, 5, 0, 0, 1);
      meas(hi, lo); chk_int("reconf_old_hi", hi, 3); chk_int("reconf_old_lo", lo, 14);
      meas(hi, lo); chk_int("reconf_new_hi", hi, 10); chk_int("reconf_new_lo", lo, 10);

      // Kill while high, then re-enable
      wait_high();
      cfg(10, 3, 0, 0, 0);
      chk("kill_out", out, 1'b0);
      chk("kill_busy", busy, 1'b0);
      cyc(100);
      chk("kill_stays_low", out, 1'b0);
      cfg(10, 3, 0, 0, 1);
      meas(hi, lo); chk_int("restart_hi", hi, 6); chk_int("restart_lo", lo, 14);

      // Asynchronous reset in the middle of a pulse
      wait_high();
      #2 rst = 1'b1;
      #1;
      chk("async_rst_out", out, 1'b0);
      chk("async_rst_busy", busy, 1'b0);
      repeat (3) @(posedge clk);
      #3 rst = 1'b0;
      cyc(40);
      chk("post_rst_idle", out, 1'b0);

      // Illegal configs keep the output low
      cfg(0, 3, 0, 0, 1);
      cyc(40);
      chk("period0_low", out, 1'b0);
      cfg(10, 0, 0, 0, 1);
      cyc(40);
      chk("on0_low", out, 1'b0);

      // Random reconfiguration against the model
      for (int i = 0; i < 200; i++) begin
         cyc(int'($urandom_range(0, 40)));
         cfg(int'($urandom_range(0, 12)), int'($urandom_range(0, 14)),
             int'($urandom_range(0, 3)), int'($urandom_range(0, 5)),
             ($urandom_range(0, 9) != 0) ? int'($urandom_range(1, 3)) : 0);
         if ($urandom_range(0, 7) == 0)
            cfg(int'($urandom_range(2, 12)), int'($urandom_range(1, 14)), 0, 0, 1);
      end
      cyc(200);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/interrupter_gen.md
Name: interrupter_gen

Overview:
- Downstream consumer of the UART config stage (`entry`).
- Takes the decoded parameter array `sh_reg` plus its `is_data_ready` strobe and generates the DRSSTC interrupter gate-enable pulse train `out`.
- Supports continuous and burst modes, with on-time safety clamping.
- New config is applied only at period boundaries; a disable command is applied immediately.

Parameters:
- CONF_PAR_NUM, 5, number of config words in `sh_reg`.
- CONF_PAR_MAX, 16, bit width of each config word.
- TICK_DIV, 50, clocks per timing tick (1 us at 50 MHz); minimum 1.
- MAX_ON_TICKS, 200, hard upper limit on the on-time, in ticks.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, asynchronous active-high reset.
- sh_reg, input, CONF_PAR_NUM x CONF_PAR_MAX, config words from the UART stage:
  - [0] period, in ticks
  - [1] on_time, in ticks
  - [2] burst_len, in pulses (0 = continuous)
  - [3] burst_gap, in ticks
  - [4] enable (nonzero = on)
- is_data_ready, input, 1, one-clock strobe; `sh_reg` is valid in the same cycle.
- out, output, 1, registered gate-enable pulse output.
- busy, output, 1, high whenever state is not IDLE.

Behaviour:
- Reset (async, rst=1):
  - out=0, busy=0, state=IDLE.
  - Prescaler=0, shadow registers=0 (disabled), pending=0.
- Prescaler:
  - Free-running counter, 0..TICK_DIV-1.
  - `tick` is high in the cycle the counter equals TICK_DIV-1.
  - All timing transitions occur only on tick cycles.
- Config capture:
  - On is_data_ready, copy `sh_reg` into a staging register and set pending=1.
  - A later strobe overwrites staging; last write wins.
- Kill:
  - If is_data_ready and sh_reg[4]==0: next clock state=IDLE, out=0.
  - Shadow is loaded from staging at the same time and pending is cleared.
  - This is independent of tick and of the current state.
- Apply point:
  - Staging is copied to shadow (pending cleared) when in IDLE, and at every OFF->next and GAP->next decision.
  - The decision uses the newly applied values.
- Effective values, computed from shadow:
  - eff_on = min(on_time, MAX_ON_TICKS, period-1).
  - off = period - eff_on.
  - Run allowed when enable!=0, period>=2 and on_time!=0; otherwise treated as disabled.
- FSM (4 states):
  - IDLE: out=0. On tick with run allowed: go to ON, cnt=eff_on, pcnt=burst_len.
  - ON: out=1. On tick, cnt-=1. When cnt==1 on a tick: go to OFF, cnt=off.
  - OFF: out=0. On tick, cnt-=1. When cnt==1 on a tick, apply, then decide:
    - Not allowed -> IDLE.
    - burst_len==0 -> ON.
    - pcnt>1 -> pcnt-=1, ON.
    - burst_gap!=0 -> GAP, cnt=burst_gap.
    - Otherwise -> ON, pcnt=burst_len.
  - GAP: out=0. On tick, cnt-=1. When cnt==1 on a tick, apply, then:
    - Not allowed -> IDLE.
    - Otherwise -> ON, pcnt=burst_len.
- Timing guarantees:
  - out is high for exactly eff_on*TICK_DIV clocks per pulse.
  - Pulse period is exactly period*TICK_DIV clocks.
  - out is driven directly from a flop (state==ON registered); there is no combinational path from inputs.
- Simultaneous events:
  - A kill has priority over a tick transition in the same cycle.
  - A strobe coinciding with an apply point is applied in that same decision.
- Width rules:
  - All counters are CONF_PAR_MAX bits; subtraction never underflows because of the period>=2 and eff_on<=period-1 rules.
  - burst_len counter saturates; no wrap.
- Mid-operation reset: out drops to 0 asynchronously; restarting requires a new enable strobe.

Decomposition:
- Shared package `drsstc_pkg`:
  - CONF_PAR_NUM / CONF_PAR_MAX constants.
  - Index constants PAR_PERIOD=0, PAR_ON=1, PAR_BURST=2, PAR_GAP=3, PAR_EN=4.
  - State enum typedef intr_state_t {IDLE, ON, OFF, GAP}.
- One sub-module, `tick_prescaler` (params TICK_DIV; ports clk, rst, tick), reused by other timing blocks.
- FSM, shadow/staging and clamping logic live in interrupter_gen.

Test Plan:
1. TICK_DIV=2, strobe period=10, on=3, burst=0, gap=0, en=1 -> out high 6 clocks, low 14, repeating; busy=1.
2. Burst: period=10, on=2, burst=3, gap=20, en=1 -> 3 pulses of 4 clocks each on a 20-clock period, then 40 clocks low, then repeat.
3. Clamp: on=50, period=10, MAX_ON_TICKS=200 -> eff_on=9 (high 18 clocks, low 2). Separately, on=300, period=1000 -> eff_on=200.
4. Mid-pulse reconfig: during ON, strobe on=5 -> current pulse keeps old width; the new width appears from the next pulse after the OFF boundary.
5. Kill: strobe en=0 while out=1 -> out=0 and busy=0 one clock after the strobe; no further pulses. Re-enabling restarts from IDLE.
6. Async rst asserted mid-ON, off-clock-edge -> out=0 immediately; period=0 or on=0 with en=1 -> out stays 0.
